// File: rtl/depack_pkg.sv
// Shared types and constants for the flit arbiter in front of the DePacketizer.
package depack_pkg;

    localparam int FLIT_W = 48;
    localparam int WORD_W = 16;
    localparam logic [WORD_W-1:0] TAIL_MARK = 16'hFFFF;

    typedef struct packed {
        logic [WORD_W-1:0] word0;
        logic [WORD_W-1:0] word1;
        logic [WORD_W-1:0] ctrl;
    } flit_t;

    typedef enum logic {
        IDLE,
        LOCKED
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin select: first requester at or after ptr, scanning upward with wrap.
module rr_pick #(
    parameter int NUM_PORTS = 4,
    parameter int PTR_W     = 2
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PTR_W-1:0]     ptr,
    output logic [NUM_PORTS-1:0] gnt
);

    logic [PTR_W:0] w_sum;
    logic           w_found;

    always_comb begin
        gnt     = '0;
        w_found = 1'b0;
        w_sum   = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            w_sum = {1'b0, ptr} + (PTR_W+1)'(k);
            if (w_sum >= (PTR_W+1)'(NUM_PORTS)) begin
                w_sum = w_sum - (PTR_W+1)'(NUM_PORTS);
            end
            if (!w_found && req[w_sum[PTR_W-1:0]]) begin
                gnt[w_sum[PTR_W-1:0]] = 1'b1;
                w_found               = 1'b1;
            end
        end
    end

endmodule

// File: rtl/depack_flit_arbiter.sv
// Wormhole round-robin arbiter: locks one port from head to tail and feeds the
// DePacketizer through a single output register, capping packet length.
module depack_flit_arbiter
    import depack_pkg::*;
#(
    parameter int              NUM_PORTS = 4,
    parameter int              MAX_FLITS = 16,
    parameter logic [15:0]     TAIL_MARK = depack_pkg::TAIL_MARK
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [FLIT_W*NUM_PORTS-1:0]   in_flit,
    input  logic [NUM_PORTS-1:0]          in_valid,
    output logic [NUM_PORTS-1:0]          in_ready,
    output logic [FLIT_W-1:0]             flitoutde,
    output logic                          de_valid,
    input  logic                          de_ready,
    output logic [NUM_PORTS-1:0]          grant,
    output logic                          busy,
    output logic                          err_overlen
);

    localparam int PTR_W = $clog2(NUM_PORTS);
    localparam int CNT_W = (MAX_FLITS > 1) ? $clog2(MAX_FLITS) : 1;

    arb_state_t            r_state;
    logic [NUM_PORTS-1:0]  r_grant;
    logic [PTR_W-1:0]      r_rr_ptr;
    logic [CNT_W-1:0]      r_flit_cnt;
    logic [FLIT_W-1:0]     r_flitoutde;
    logic                  r_de_valid;
    logic                  r_err;

    arb_state_t            w_state_next;
    logic [NUM_PORTS-1:0]  w_grant_next;
    logic [PTR_W-1:0]      w_rr_next;
    logic [CNT_W-1:0]      w_cnt_next;
    logic [FLIT_W-1:0]     w_flit_next;
    logic                  w_dv_next;
    logic                  w_err_next;

    logic [NUM_PORTS-1:0]  w_pick;
    logic [FLIT_W-1:0]     w_sel_raw;
    flit_t                 w_sel_flit;
    logic [PTR_W-1:0]      w_after_grant;
    logic                  w_can_load;
    logic                  w_accept;
    logic                  w_is_tail;
    logic                  w_cap;

    rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .PTR_W     (PTR_W)
    ) u_rr_pick (
        .req (in_valid),
        .ptr (r_rr_ptr),
        .gnt (w_pick)
    );

    // Grant is one-hot, so OR-ing the masked lanes is a plain mux.
    always_comb begin
        w_sel_raw     = '0;
        w_after_grant = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (r_grant[i]) begin
                w_sel_raw     = w_sel_raw | in_flit[i*FLIT_W +: FLIT_W];
                w_after_grant = (i == NUM_PORTS-1) ? '0 : PTR_W'(i + 1);
            end
        end
    end

    assign w_sel_flit = flit_t'(w_sel_raw);
    assign w_can_load = !r_de_valid || de_ready;
    assign in_ready   = (r_state == LOCKED && w_can_load) ? r_grant : '0;
    assign w_accept   = |(in_valid & in_ready);
    assign w_is_tail  = (w_sel_flit.ctrl == TAIL_MARK);
    assign w_cap      = (r_flit_cnt == CNT_W'(MAX_FLITS - 1));

    always_comb begin
        w_state_next = r_state;
        w_grant_next = r_grant;
        w_rr_next    = r_rr_ptr;
        w_cnt_next   = r_flit_cnt;
        w_flit_next  = r_flitoutde;
        w_dv_next    = r_de_valid;
        w_err_next   = r_err;
        case (r_state)
            IDLE: begin
                if (|in_valid) begin
                    w_grant_next = w_pick;
                    w_state_next = LOCKED;
                end
            end
            LOCKED: begin
                if (w_accept) begin
                    w_flit_next = w_sel_flit;
                    w_dv_next   = 1'b1;
                    if (w_is_tail || w_cap) begin
                        w_state_next = IDLE;
                        w_grant_next = '0;
                        w_rr_next    = w_after_grant;
                        w_cnt_next   = '0;
                        if (!w_is_tail) begin
                            w_err_next = 1'b1;
                        end
                    end else begin
                        w_cnt_next = r_flit_cnt + CNT_W'(1);
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
        if (!w_accept && r_de_valid && de_ready) begin
            w_dv_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_rr_ptr    <= '0;
            r_flit_cnt  <= '0;
            r_flitoutde <= '0;
            r_de_valid  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_grant     <= w_grant_next;
            r_rr_ptr    <= w_rr_next;
            r_flit_cnt  <= w_cnt_next;
            r_flitoutde <= w_flit_next;
            r_de_valid  <= w_dv_next;
            r_err       <= w_err_next;
        end
    end

    assign flitoutde   = r_flitoutde;
    assign de_valid    = r_de_valid;
    assign grant       = r_grant;
    assign busy        = (r_state == LOCKED);
    assign err_overlen = r_err;

endmodule

// File: tb/tb_depack_flit_arbiter.sv
// Directed bench for depack_flit_arbiter: per-cycle comparison against a queue-based
// behavioural model, plus literal expectations for grant order and output streams.
module tb_depack_flit_arbiter;

    localparam int NP = 4;
    localparam int MF = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [48*NP-1:0]  in_flit;
    logic [NP-1:0]     in_valid;
    logic [NP-1:0]     in_ready;
    logic [47:0]       flitoutde;
    logic              de_valid;
    logic              de_ready;
    logic [NP-1:0]     grant;
    logic              busy;
    logic              err_overlen;

    always #5 clk = ~clk;

    depack_flit_arbiter #(
        .NUM_PORTS (NP),
        .MAX_FLITS (MF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_flit     (in_flit),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .flitoutde   (flitoutde),
        .de_valid    (de_valid),
        .de_ready    (de_ready),
        .grant       (grant),
        .busy        (busy),
        .err_overlen (err_overlen)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [47:0] q [NP][$];
    logic [47:0] cons_q [$];
    int          gnt_q [$];

    // Model state: locked port (-1 = none), round-robin start, flits taken, output register.
    int          m_lock;
    int          m_rr;
    int          m_cnt;
    logic        m_valid;
    logic [47:0] m_data;
    logic        m_err;
    logic [NP-1:0] prev_grant;

    function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void m_reset();
        m_lock     = -1;
        m_rr       = 0;
        m_cnt      = 0;
        m_valid    = 1'b0;
        m_data     = '0;
        m_err      = 1'b0;
        prev_grant = '0;
    endfunction

    function automatic int oh2idx(logic [NP-1:0] v);
        for (int i = 0; i < NP; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic void apply();
        for (int i = 0; i < NP; i++) begin
            if (q[i].size() != 0) begin
                in_valid[i]         = 1'b1;
                in_flit[i*48 +: 48] = q[i][0];
            end else begin
                in_valid[i]         = 1'b0;
                in_flit[i*48 +: 48] = '0;
            end
        end
    endfunction

    function automatic bit qs_empty();
        for (int i = 0; i < NP; i++) begin
            if (q[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic step();
        logic [NP-1:0] acc;
        @(negedge clk);
        acc = in_valid & in_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NP; i++) begin
            if (acc[i]) void'(q[i].pop_front());
        end
        apply();
    endtask

    task automatic drain(int budget);
        int n = 0;
        while ((!qs_empty() || de_valid || busy) && n < budget) begin
            step();
            n++;
        end
        check("drain_done", 64'(n < budget), 64'd1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        for (int i = 0; i < NP; i++) q[i].delete();
        apply();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Compare process: check registered outputs against the model, then advance it
    // with the inputs that the coming rising edge will sample.
    initial begin
        logic [NP-1:0] exp_g;
        logic          can;
        logic [47:0]   fl;
        m_reset();
        forever begin
            @(negedge clk);
            if (!reset) begin
                m_reset();
            end else begin
                exp_g = (m_lock >= 0) ? NP'(1 << m_lock) : '0;
                can   = !m_valid || de_ready;
                check("grant", 64'(grant), 64'(exp_g));
                check("busy", 64'(busy), 64'(m_lock >= 0));
                check("de_valid", 64'(de_valid), 64'(m_valid));
                check("flitoutde", 64'(flitoutde), 64'(m_data));
                check("err_overlen", 64'(err_overlen), 64'(m_err));
                check("in_ready", 64'(in_ready), 64'((can && m_lock >= 0) ? exp_g : '0));

                if (de_valid && de_ready) begin
                    cons_q.push_back(flitoutde);
                    $display("%0t out flit %012h", $time, flitoutde);
                end
                if (grant != '0 && prev_grant == '0) gnt_q.push_back(oh2idx(grant));
                prev_grant = grant;

                if (m_lock >= 0 && can && in_valid[m_lock]) begin
                    fl      = in_flit[m_lock*48 +: 48];
                    m_data  = fl;
                    m_valid = 1'b1;
                    m_cnt++;
                    if (fl[15:0] == 16'hFFFF || m_cnt == MF) begin
                        if (fl[15:0] != 16'hFFFF) m_err = 1'b1;
                        m_rr   = (m_lock + 1) % NP;
                        m_lock = -1;
                        m_cnt  = 0;
                    end
                end else begin
                    if (m_valid && de_ready) m_valid = 1'b0;
                    if (m_lock < 0) begin
                        for (int k = 0; k < NP; k++) begin
                            if (m_lock < 0 && in_valid[(m_rr + k) % NP]) m_lock = (m_rr + k) % NP;
                        end
                    end
                end
            end
        end
    end

    initial begin
        reset    = 1'b0;
        de_ready = 1'b1;
        in_valid = '0;
        in_flit  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_de_valid", 64'(de_valid), 64'd0);
        check("rst_flitoutde", 64'(flitoutde), 64'd0);
        check("rst_err", 64'(err_overlen), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        reset = 1'b1;

        // Single tail flit from port 0
        q[0].push_back(48'h1234_ABCD_FFFF);
        apply();
        step();
        check("t1_grant", 64'(grant), 64'h1);
        check("t1_busy", 64'(busy), 64'd1);
        step();
        check("t1_de_valid", 64'(de_valid), 64'd1);
        check("t1_flit", 64'(flitoutde), 64'h1234_ABCD_FFFF);
        check("t1_busy_drop", 64'(busy), 64'd0);
        drain(20);

        // Ports 0,1,3 from reset: order 0,1,3,0
        do_reset();
        cons_q.delete();
        gnt_q.delete();
        q[0].push_back(48'hA0A0_0000_FFFF);
        q[0].push_back(48'hA1A1_0000_FFFF);
        q[1].push_back(48'hB0B0_0000_FFFF);
        q[3].push_back(48'hD0D0_0000_FFFF);
        apply();
        drain(40);
        check("t2_ngrants", 64'(gnt_q.size()), 64'd4);
        if (gnt_q.size() == 4) begin
            check("t2_g0", 64'(gnt_q[0]), 64'd0);
            check("t2_g1", 64'(gnt_q[1]), 64'd1);
            check("t2_g2", 64'(gnt_q[2]), 64'd3);
            check("t2_g3", 64'(gnt_q[3]), 64'd0);
        end
        check("t2_nflits", 64'(cons_q.size()), 64'd4);
        if (cons_q.size() == 4) begin
            check("t2_f2", 64'(cons_q[2]), 64'hD0D0_0000_FFFF);
            check("t2_f3", 64'(cons_q[3]), 64'hA1A1_0000_FFFF);
        end

        // Port 2 three-flit packet, port 1 arrives after the lock
        cons_q.delete();
        gnt_q.delete();
        q[2].push_back(48'h3232_6767_0000);
        q[2].push_back(48'h6547_4576_0001);
        q[2].push_back(48'h6969_4566_FFFF);
        apply();
        step();
        check("t3_grant", 64'(grant), 64'h4);
        q[1].push_back(48'hB1B1_0000_FFFF);
        apply();
        drain(40);
        check("t3_ngrants", 64'(gnt_q.size()), 64'd2);
        if (gnt_q.size() == 2) begin
            check("t3_g0", 64'(gnt_q[0]), 64'd2);
            check("t3_g1", 64'(gnt_q[1]), 64'd1);
        end
        check("t3_nflits", 64'(cons_q.size()), 64'd4);
        if (cons_q.size() == 4) begin
            check("t3_f0", 64'(cons_q[0]), 64'h3232_6767_0000);
            check("t3_f1", 64'(cons_q[1]), 64'h6547_4576_0001);
            check("t3_f2", 64'(cons_q[2]), 64'h6969_4566_FFFF);
            check("t3_f3", 64'(cons_q[3]), 64'hB1B1_0000_FFFF);
        end

        // de_ready low for 5 cycles mid-packet on port 1
        cons_q.delete();
        q[1].push_back(48'h1111_0000_0000);
        q[1].push_back(48'h1111_0001_0000);
        q[1].push_back(48'h1111_0002_FFFF);
        apply();
        step();
        step();
        de_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t4_in_ready", 64'(in_ready), 64'd0);
            check("t4_hold", 64'(flitoutde), 64'h1111_0000_0000);
        end
        de_ready = 1'b1;
        drain(40);
        check("t4_nflits", 64'(cons_q.size()), 64'd3);
        if (cons_q.size() == 3) begin
            check("t4_f0", 64'(cons_q[0]), 64'h1111_0000_0000);
            check("t4_f1", 64'(cons_q[1]), 64'h1111_0001_0000);
            check("t4_f2", 64'(cons_q[2]), 64'h1111_0002_FFFF);
        end

        // Over-length: 6 non-tail flits with a cap of 4
        cons_q.delete();
        gnt_q.delete();
        check("t5_err_before", 64'(err_overlen), 64'd0);
        for (int k = 0; k < 6; k++) q[0].push_back(48'h5050_0000_0000 | (48'(k) << 16));
        apply();
        repeat (16) step();
        check("t5_err", 64'(err_overlen), 64'd1);
        check("t5_busy", 64'(busy), 64'd1);
        check("t5_grant", 64'(grant), 64'h1);
        check("t5_ngrants", 64'(gnt_q.size()), 64'd2);
        check("t5_nflits", 64'(cons_q.size()), 64'd6);
        if (cons_q.size() == 6) begin
            check("t5_f3", 64'(cons_q[3]), 64'h5050_0003_0000);
            check("t5_f5", 64'(cons_q[5]), 64'h5050_0005_0000);
        end

        // Reset mid-packet, then a fresh arbitration from port 0
        q[0].push_back(48'h6000_0000_0000);
        apply();
        #2;
        reset = 1'b0;
        #1;
        check("t6_grant", 64'(grant), 64'd0);
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_de_valid", 64'(de_valid), 64'd0);
        check("t6_flitoutde", 64'(flitoutde), 64'd0);
        check("t6_err", 64'(err_overlen), 64'd0);
        check("t6_in_ready", 64'(in_ready), 64'd0);
        for (int i = 0; i < NP; i++) q[i].delete();
        apply();
        @(posedge clk);
        #1;
        reset = 1'b1;
        cons_q.delete();
        gnt_q.delete();
        q[0].push_back(48'h7070_0000_FFFF);
        q[1].push_back(48'h7171_0000_FFFF);
        apply();
        step();
        check("t6_first_grant", 64'(grant), 64'h1);
        drain(40);
        check("t6_ngrants", 64'(gnt_q.size()), 64'd2);
        if (gnt_q.size() == 2) begin
            check("t6_g0", 64'(gnt_q[0]), 64'd0);
            check("t6_g1", 64'(gnt_q[1]), 64'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/depack_flit_arbiter.md
# depack_flit_arbiter

Wormhole round-robin arbiter sharing one `DePacketizer` among `NUM_PORTS` flit sources. It accepts 48-bit flits over per-port valid/ready handshakes and locks the grant to one port from head flit to tail flit. It drives the depacketizer's `flitoutde` input through a single output register. It also enforces a maximum packet length and flags over-length packets.

## Interface
- `NUM_PORTS`, 4: number of requesters, 2..8.
- `MAX_FLITS`, 16: maximum flits per packet, including the tail; minimum 1.
- `TAIL_MARK`, 16'hFFFF: value of flit[15:0] that marks a tail flit.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low; asserting it (low) clears all state immediately.
- `in_flit` in 48×NUM_PORTS: flit from port i on bits [48i+47:48i].
- `in_valid` in NUM_PORTS: port i presents a flit.
- `in_ready` out NUM_PORTS: port i flit accepted when `in_valid[i] & in_ready[i]`.
- `flitoutde` out 48: registered flit to the DePacketizer.
- `de_valid` out 1: `flitoutde` holds a valid flit.
- `de_ready` in 1: DePacketizer consumes `flitoutde` this cycle.
- `grant` out NUM_PORTS: one-hot locked port, or 0.
- `busy` out 1: a packet is in progress (state LOCKED).
- `err_overlen` out 1: sticky; a packet reached MAX_FLITS without a tail. Cleared only by reset.

## Operation
- Flit layout:
  - [47:32] word 0.
  - [31:16] word 1.
  - [15:0] control; equal to TAIL_MARK means tail.
  - The first flit after grant is the head.
  - A single flit with a tail mark is a complete packet.
- States are IDLE and LOCKED.
- **IDLE**
  - `in_ready` is 0.
  - If any `in_valid` is set, the arbiter picks the first requesting port at or after `rr_ptr`, scanning upward with wrap.
  - It registers the pick as `grant` and moves to LOCKED.
  - With no requests it stays in IDLE.
- **LOCKED**
  - `in_ready[g] = can_load` and all other ready bits are 0.
  - `can_load = !de_valid | de_ready`.
  - Each accepted flit loads `flitoutde`, sets `de_valid`, and increments `flit_cnt`.
  - When the accepted flit is a tail, or `flit_cnt == MAX_FLITS-1` at acceptance, the arbiter moves to IDLE, clears `grant`, sets `rr_ptr = g+1 mod NUM_PORTS`, and resets `flit_cnt` to 0.
  - The over-length release, where the cap is hit without a tail mark, also sets `err_overlen`. The flit is forwarded unchanged.
- **Output register**
  - If `de_valid & de_ready` and no new flit is accepted, `de_valid` clears.
  - On accept plus consume in the same cycle, the register reloads and `de_valid` stays 1.
  - `flitoutde` holds its value when not loaded.
- Ports that are not granted keep `in_valid` asserted and are never dropped.
- The arbiter never reorders flits within a packet and never interleaves packets.

## Timing
- Reset values:
  - `flitoutde` = 0.
  - `de_valid` = 0, `in_ready` = 0, `grant` = 0, `busy` = 0, `err_overlen` = 0.
  - `rr_ptr` = 0, `flit_cnt` = 0, state = IDLE.
- First flit of a packet: `in_valid` rises in cycle N. `grant` and `busy` are set at edge N+1. The flit is accepted in cycle N+1 if `can_load`, and `de_valid` is set at edge N+2.
- Steady state is one flit per cycle while `de_ready` = 1.
- Between packets there is at least one bubble cycle (the IDLE re-arbitration cycle).
- `in_ready` is combinational from state, `grant`, `de_valid` and `de_ready`. No other output is combinational.
- `de_ready` low stalls the granted port with no data loss.
- A reset assertion mid-packet drops the in-flight flit and returns to IDLE. The partial packet is lost; upstream is responsible for it.
- `flit_cnt` width is `$clog2(MAX_FLITS)`, minimum 1. It never wraps because release happens at MAX_FLITS-1.
- With MAX_FLITS = 1, every flit releases. `err_overlen` is set only when the flit lacks the tail mark.

## Structure
- Shared package `depack_pkg` holds:
  - `FLIT_W` = 48, `WORD_W` = 16, `TAIL_MARK`.
  - A typedef for the flit fields.
  - An enum `arb_state_t {IDLE, LOCKED}`.
- One sub-module, `rr_pick`: combinational round-robin priority select (request vector, pointer → one-hot grant). The top level holds the FSM, counter, and output register.

## Test plan
- Single port 0, flit 48'h1234_ABCD_FFFF → `grant` = 4'b0001 one cycle after `in_valid`; `flitoutde` = 48'h1234_ABCD_FFFF with `de_valid` the following cycle; `busy` drops.
- Ports 0, 1 and 3 request simultaneously with single-flit tail packets from reset → grant order 0, 1, 3, 0; each grant lasts one accepted flit plus one IDLE cycle.
- Port 2 sends 3-flit packet 48'h3232_6767_0000, 48'h6547_4576_0001, 48'h6969_4566_FFFF while port 1 requests → all three go out contiguously before `grant` becomes 4'b0010.
- `de_ready` held low for 5 cycles mid-packet → `in_ready` = 0, `flitoutde` stable, no duplicate or lost flit after release.
- MAX_FLITS = 4, port 0 streams 6 non-tail flits → release after the 4th, `err_overlen` = 1 and sticky; remaining flits re-arbitrate as a new packet.
- Reset asserted low mid-packet → all outputs zero immediately; after deassert, a fresh request is granted starting from port 0.
